// File: rtl/pipe_stage_chain.sv
// Valid/ready pipeline register chain with bubble collapsing and synchronous flush.
// Optional stall counter port and logic are enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] stageValid_q;
    logic [DEPTH-1:0] stageValid_d;
    logic [WIDTH-1:0] stageData_q [DEPTH];
    logic [WIDTH-1:0] stageData_d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] srcValid;
    logic [WIDTH-1:0] srcData [DEPTH];
    logic [OCC_W-1:0] occCount;

    // A stage may advance when the output drains or any stage at or beyond it is empty.
    always_comb begin
        logic hole;
        adv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hole = 1'b0;
            for (int j = i; j < DEPTH; j++) begin
                hole = hole | ~stageValid_q[j];
            end
            adv[i] = out_ready | hole;
        end
    end

    always_comb begin
        srcValid[0] = in_valid;
        srcData[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            srcValid[i] = stageValid_q[i-1];
            srcData[i]  = stageData_q[i-1];
        end
    end

    // Flush kills every valid bit but never touches the data registers.
    always_comb begin
        stageValid_d = stageValid_q;
        stageData_d  = stageData_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                stageValid_d[i] = 1'b0;
            end else if (adv[i]) begin
                stageValid_d[i] = srcValid[i];
                if (srcValid[i]) begin
                    stageData_d[i] = srcData[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stageValid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stageData_q[i] <= '0;
            end
        end else begin
            stageValid_q <= stageValid_d;
            stageData_q  <= stageData_d;
        end
    end

    always_comb begin
        occCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occCount = occCount + OCC_W'(stageValid_q[i]);
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = stageValid_q[DEPTH-1];
    assign out_data  = stageData_q[DEPTH-1];
    assign occupancy = occCount;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stallCnt_q;

    // Saturating count of cycles where the output is held back; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else if (out_valid && !out_ready && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives a DEPTH=2 and a DEPTH=4 chain with shared stimulus and checks both against
// an entry-position reference model; stall counter checks need PIPE_STALL_CNT_EN.
module tb_pipe_stage_chain;

    logic        clock = 1'b0;
    logic        rstN;
    logic        flush;
    logic        inValid;
    logic [31:0] inData;
    logic        outReady;

    logic        inRdy2, outV2, inRdy4, outV4;
    logic [31:0] outD2, outD4;
    logic [1:0]  occ2;
    logic [2:0]  occ4;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall2, stall4;
`endif

    int checks = 0;
    int errors = 0;

    int          D [2] = '{2, 4};
    int          mCnt [2];
    int          mPos [2][8];
    logic [31:0] mDat [2][8];
    logic [31:0] mStall [2];

    always #5 clock = ~clock;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(2)) dut2 (
        .clk(clock), .rst_n(rstN), .flush(flush),
        .in_valid(inValid), .in_ready(inRdy2), .in_data(inData),
        .out_valid(outV2), .out_ready(outReady), .out_data(outD2),
        .occupancy(occ2)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall2)
`endif
    );

    pipe_stage_chain #(.WIDTH(32), .DEPTH(4)) dut4 (
        .clk(clock), .rst_n(rstN), .flush(flush),
        .in_valid(inValid), .in_ready(inRdy4), .in_data(inData),
        .out_valid(outV4), .out_ready(outReady), .out_data(outD4),
        .occupancy(occ4)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall4)
`endif
    );

    // Entries are kept oldest-first with their stage position; index 0 is the oldest.
    function automatic logic expValid(input int k);
        return (mCnt[k] > 0) && (mPos[k][0] == D[k] - 1);
    endfunction

    function automatic logic expInReady(input int k);
        return outReady || (mCnt[k] < D[k]);
    endfunction

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            mCnt[k]   = 0;
            mStall[k] = '0;
        end
    endtask

    // Each entry moves one stage forward unless it is part of the stalled block at the output.
    task automatic modelStep(input int k);
        int   depth;
        int   lim;
        int   n;
        int   np;
        logic rdy;
        depth = D[k];
        rdy   = expInReady(k);
        if (expValid(k) && !outReady && mStall[k] != 32'hFFFF_FFFF) mStall[k] = mStall[k] + 1;
        lim = depth - 1;
        n   = 0;
        for (int j = 0; j < mCnt[k]; j++) begin
            if (mPos[k][j] == depth - 1 && outReady) continue;
            np = (mPos[k][j] + 1 < lim) ? mPos[k][j] + 1 : lim;
            mPos[k][n] = np;
            mDat[k][n] = mDat[k][j];
            lim = np - 1;
            n++;
        end
        if (inValid && rdy) begin
            mPos[k][n] = 0;
            mDat[k][n] = inData;
            n++;
        end
        if (flush) n = 0;
        mCnt[k] = n;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("in_ready d2", 32'(inRdy2), 32'(expInReady(0)));
        checkOutput("out_valid d2", 32'(outV2), 32'(expValid(0)));
        checkOutput("occupancy d2", 32'(occ2), 32'(mCnt[0]));
        if (expValid(0)) checkOutput("out_data d2", outD2, mDat[0][0]);
        checkOutput("in_ready d4", 32'(inRdy4), 32'(expInReady(1)));
        checkOutput("out_valid d4", 32'(outV4), 32'(expValid(1)));
        checkOutput("occupancy d4", 32'(occ4), 32'(mCnt[1]));
        if (expValid(1)) checkOutput("out_data d4", outD4, mDat[1][0]);
`ifdef PIPE_STALL_CNT_EN
        checkOutput("stall_cnt d2", stall2, mStall[0]);
        checkOutput("stall_cnt d4", stall4, mStall[1]);
`endif
    endtask

    // One clock: drive inputs, check settled outputs at the falling edge, then advance the model.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
        inValid  = v;
        inData   = d;
        outReady = r;
        flush    = f;
        @(negedge clock);
        checkAll();
        @(posedge clock);
        modelStep(0);
        modelStep(1);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, r, 1'b0);
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
        resetModel();
        #12;
        checkAll();
        checkOutput("reset out_data d2", outD2, 32'h0);
        checkOutput("reset out_data d4", outD4, 32'h0);
        rstN = 1'b1;
        @(posedge clock); #1;

        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
        idle(5, 1'b1);

        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
        inValid = 1'b1; inData = 32'hC; outReady = 1'b0;
        #2;
        checkOutput("backpressure occupancy d2", 32'(occ2), 32'd2);
        checkOutput("backpressure in_ready d2", 32'(inRdy2), 32'd0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
        idle(6, 1'b1);

        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
        idle(2, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0);
        idle(4, 1'b0);
        checkOutput("collapse occupancy d4", 32'(occ4), 32'd2);
        checkOutput("collapse valid bits d4", 32'(dut4.stageValid_q), 32'b1100);
        idle(5, 1'b1);

        applyStimulus(1'b1, 32'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h32, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b1);
        inValid = 1'b0; flush = 1'b0;
        #2;
        checkOutput("flush occupancy d4", 32'(occ4), 32'd0);
        checkOutput("flush out_valid d4", 32'(outV4), 32'd0);
        idle(5, 1'b1);

        applyStimulus(1'b1, 32'h61, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h62, 1'b0, 1'b0);
        inValid = 1'b0; inData = '0; outReady = 1'b0; flush = 1'b0;
        rstN = 1'b0;
        #1;
        resetModel();
        checkOutput("midreset out_valid d2", 32'(outV2), 32'd0);
        checkOutput("midreset occupancy d2", 32'(occ2), 32'd0);
        checkOutput("midreset in_ready d2", 32'(inRdy2), 32'd1);
        checkOutput("midreset out_data d2", outD2, 32'h0);
        checkOutput("midreset occupancy d4", 32'(occ4), 32'd0);
        #2;
        rstN = 1'b1;
        @(posedge clock); #1;

`ifdef PIPE_STALL_CNT_EN
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
        idle(12, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        idle(3, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 10) < 7, ($urandom % 25) == 0);
        end
        idle(6, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
